// File: rtl/spi_slave_resp_if.sv
// Bus and stream signals of the SPI mode-0 responder, grouped for port connection.
interface spi_slave_resp_if;
  logic       spi_SCLK;
  logic       spi_MOSI;
  logic       spi_SS_n;
  logic       spi_MISO;
  logic       spi_MISO_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       ovr_clr;
  logic       busy;

  modport slave (
    input  spi_SCLK, spi_MOSI, spi_SS_n, tx_data, tx_valid, rx_ready, ovr_clr,
    output spi_MISO, spi_MISO_oe, tx_ready, rx_data, rx_valid, overrun, busy
  );

  modport master (
    output spi_SCLK, spi_MOSI, spi_SS_n, tx_data, tx_valid, rx_ready, ovr_clr,
    input  spi_MISO, spi_MISO_oe, tx_ready, rx_data, rx_valid, overrun, busy
  );
endinterface

// File: rtl/spi_slave_resp.sv
// SPI mode-0 responder oversampled in the sys_clk domain, with a 1-entry TX holding register.
// Define SPI_SLAVE_RXFIFO_EN to replace the single RX holding register with an RX FIFO.
module spi_slave_resp #(
  parameter logic [7:0] DUMMY_BYTE = 8'hFF
`ifdef SPI_SLAVE_RXFIFO_EN
  , parameter int unsigned RX_FIFO_DEPTH = 4
`endif
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  spi_slave_resp_if.slave  bus
);

  typedef enum logic {StIdle, StShift} state_e;

  state_e     state_q, state_d;
  logic [1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic       sclk_prev_q, ss_prev_q;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, tx_hold_q;
  logic       tx_full_q, tx_full_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic       load_pend_q, load_pend_d;
  logic       ovr_q;
  logic       push, load, tx_wr, pop, accept, drop;

  logic sclk_s, mosi_s, ss_s, sclk_rise, sclk_fall, ss_fall;
  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign ss_s      = ss_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // ss_prev resets low so a frame already running at reset release is not taken as a start.
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign tx_wr     = bus.tx_valid & ~tx_full_q;

  always_comb begin
    state_d     = state_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    bitcnt_d    = bitcnt_q;
    load_pend_d = load_pend_q;
    push        = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          load        = 1'b1;
          bitcnt_d    = 4'd0;
          load_pend_d = 1'b0;
          state_d     = StShift;
        end
      end
      StShift: begin
        if (sclk_rise) begin
          rx_sh_d  = {rx_sh_q[6:0], mosi_s};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            push        = 1'b1;
            load_pend_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (load_pend_q) begin
            load        = 1'b1;
            load_pend_d = 1'b0;
            bitcnt_d    = 4'd0;
          end else begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end
        if (ss_s) state_d = StIdle;
      end
    endcase
    if (load) tx_sh_d = tx_full_q ? tx_hold_q : DUMMY_BYTE;
    tx_full_d = (tx_full_q & ~load) | tx_wr;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      tx_hold_q   <= '0;
      tx_full_q   <= 1'b0;
      bitcnt_q    <= '0;
      load_pend_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[0], bus.spi_SCLK};
      mosi_sync_q <= {mosi_sync_q[0], bus.spi_MOSI};
      ss_sync_q   <= {ss_sync_q[0], bus.spi_SS_n};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      if (tx_wr) tx_hold_q <= bus.tx_data;
      tx_full_q   <= tx_full_d;
      bitcnt_q    <= bitcnt_d;
      load_pend_q <= load_pend_d;
      ovr_q       <= (ovr_q & ~bus.ovr_clr) | drop;
    end
  end

`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int unsigned Aw = $clog2(RX_FIFO_DEPTH);

  logic [7:0]  mem_q [RX_FIFO_DEPTH];
  logic [Aw:0] wptr_q, rptr_q;
  logic        empty, full;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign pop    = ~empty & bus.rx_ready;
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < int'(RX_FIFO_DEPTH); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (accept) begin
        mem_q[wptr_q[Aw-1:0]] <= rx_sh_d;
        wptr_q                <= wptr_q + (Aw+1)'(1);
      end
      if (pop) rptr_q <= rptr_q + (Aw+1)'(1);
    end
  end

  assign bus.rx_data  = mem_q[rptr_q[Aw-1:0]];
  assign bus.rx_valid = ~empty;
`else
  logic [7:0] rx_q;
  logic       rx_full_q;

  assign pop    = rx_full_q & bus.rx_ready;
  assign accept = push & (~rx_full_q | pop);
  assign drop   = push & rx_full_q & ~pop;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_q      <= '0;
      rx_full_q <= 1'b0;
    end else begin
      if (accept) rx_q <= rx_sh_d;
      rx_full_q <= accept | (rx_full_q & ~pop);
    end
  end

  assign bus.rx_data  = rx_q;
  assign bus.rx_valid = rx_full_q;
`endif

  assign bus.spi_MISO    = (state_q == StShift) & tx_sh_q[7];
  assign bus.spi_MISO_oe = (state_q == StShift);
  assign bus.busy        = (state_q == StShift);
  assign bus.tx_ready    = ~tx_full_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_spi_slave_resp.sv
// Self-checking bench for spi_slave_resp: directed cases plus randomized frames against a
// queue-based model of the TX holding register and RX storage.
module tb_spi_slave_resp;
  localparam int HALF = 8;
`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  spi_slave_resp_if bus ();

  spi_slave_resp dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  bit         exp_ovr = 1'b0;
  bit         tx_pend = 1'b0;
  logic [7:0] tx_val = 8'h00;
  logic [7:0] mo[8];
  logic [7:0] mi;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Byte the master should see next: the queued TX byte once, otherwise the dummy.
  function automatic logic [7:0] next_tx();
    if (tx_pend) begin
      tx_pend = 1'b0;
      return tx_val;
    end
    return 8'hFF;
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < CAP) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", 8'(bus.spi_MISO), 8'h00);
    check("rst_oe", 8'(bus.spi_MISO_oe), 8'h00);
    check("rst_tx_ready", 8'(bus.tx_ready), 8'h01);
    check("rst_rx_valid", 8'(bus.rx_valid), 8'h00);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_overrun", 8'(bus.overrun), 8'h00);
    check("rst_busy", 8'(bus.busy), 8'h00);
  endtask

  task automatic tx_write(input logic [7:0] v);
    check("tx_ready_pre", 8'(bus.tx_ready), 8'h01);
    bus.tx_data  = v;
    bus.tx_valid = 1'b1;
    step(1);
    bus.tx_valid = 1'b0;
    tx_pend = 1'b1;
    tx_val  = v;
    check("tx_ready_post", 8'(bus.tx_ready), 8'h00);
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_valid"}, 8'(bus.rx_valid), 8'h01);
    check({tag, "_data"}, bus.rx_data, exp_q[0]);
    bus.rx_ready = 1'b1;
    step(1);
    bus.rx_ready = 1'b0;
    void'(exp_q.pop_front());
  endtask

  // Clock nbits MSB-first; pop_last asserts rx_ready only in the cycle the 8th bit is pushed.
  task automatic spi_bits(input logic [7:0] d, input int nbits, input bit pop_last,
                          output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_MOSI = d[7-i];
      step(HALF);
      got[7-i] = bus.spi_MISO;
      bus.spi_SCLK = 1'b1;
      if (pop_last && i == 7) begin
        step(2);
        check("coinc_head", bus.rx_data, exp_q[0]);
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
        void'(exp_q.pop_front());
        step(HALF - 3);
      end else begin
        step(HALF);
      end
      bus.spi_SCLK = 1'b0;
    end
  endtask

  task automatic do_frame(input int nbytes, input int last_bits, input bit pop_last,
                          input bit pop_each);
    logic [7:0] e;
    int nb;
    bus.spi_SS_n = 1'b0;
    step(HALF);
    for (int b = 0; b < nbytes; b++) begin
      nb = (b == nbytes - 1) ? last_bits : 8;
      e = next_tx();
      spi_bits(mo[b], nb, pop_last && (b == nbytes - 1) && (nb == 8), mi);
      if (nb == 8) begin
        check("miso_byte", mi, e);
        model_push(mo[b]);
        if (pop_each) pop_one("pop_each");
      end
    end
    step(HALF);
    bus.spi_SS_n = 1'b1;
    step(6);
  endtask

  task automatic drain();
    check("overrun", 8'(bus.overrun), 8'(exp_ovr));
    while (exp_q.size() > 0) pop_one("drain");
    check("drained_valid", 8'(bus.rx_valid), 8'h00);
    if (exp_ovr) begin
      bus.ovr_clr = 1'b1;
      step(1);
      bus.ovr_clr = 1'b0;
      exp_ovr = 1'b0;
      check("ovr_cleared", 8'(bus.overrun), 8'h00);
    end
  endtask

  initial begin
    bus.spi_SCLK = 1'b0;
    bus.spi_MOSI = 1'b0;
    bus.spi_SS_n = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    bus.ovr_clr  = 1'b0;
    step(3);
    check_reset_outputs();
    sys_rst_n = 1'b1;
    step(5);

    // Queued A5 returned while 3C is received.
    tx_write(8'hA5);
    mo[0] = 8'h3C;
    do_frame(1, 8, 1'b0, 1'b0);
    check("tx_ready_after", 8'(bus.tx_ready), 8'h01);
    drain();

    // Nothing queued: dummy bytes, two bytes popped as they arrive.
    mo[0] = 8'h01;
    mo[1] = 8'h02;
    do_frame(2, 8, 1'b0, 1'b1);
    drain();

    // Aborted partial byte is discarded.
    mo[0] = 8'hE6;
    do_frame(1, 5, 1'b0, 1'b0);
    mo[0] = 8'h77;
    do_frame(1, 8, 1'b0, 1'b0);
    drain();

    // Overflow: one byte beyond capacity is dropped.
    for (int i = 0; i < CAP + 1; i++) mo[i] = 8'($urandom);
    do_frame(CAP + 1, 8, 1'b0, 1'b0);
    drain();

    // Fill storage, then push with a coincident pop: nothing lost.
    for (int i = 0; i < CAP; i++) mo[i] = 8'($urandom);
    do_frame(CAP, 8, 1'b0, 1'b0);
    mo[0] = 8'h5D;
    do_frame(1, 8, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 8; i++) mo[i] = 8'($urandom);
    do_frame(8, 8, 1'b0, 1'b1);
    drain();

    // Reset mid-byte, with a TX byte written during the frame.
    bus.spi_SS_n = 1'b0;
    step(HALF);
    spi_bits(8'h5A, 4, 1'b0, mi);
    tx_write(8'h11);
    sys_rst_n = 1'b0;
    step(1);
    check_reset_outputs();
    sys_rst_n = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    tx_pend = 1'b0;
    step(2);
    spi_bits(8'hF0, 4, 1'b0, mi);
    check("ignored_busy", 8'(bus.busy), 8'h00);
    check("ignored_oe", 8'(bus.spi_MISO_oe), 8'h00);
    step(HALF);
    bus.spi_SS_n = 1'b1;
    step(6);
    tx_write(8'hC3);
    mo[0] = 8'h96;
    do_frame(1, 8, 1'b0, 1'b0);
    drain();

    // Randomized frames.
    for (int it = 0; it < 25; it++) begin
      int nbytes, last_bits;
      bit pe;
      nbytes = int'($urandom_range(1, CAP + 1));
      for (int i = 0; i < nbytes; i++) mo[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      last_bits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      pe = ($urandom_range(0, 2) == 0);
      do_frame(nbytes, last_bits, 1'b0, pe);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
